// File: rtl/core_seq_ctrl_if.sv
`default_nettype none
// ==========================================================================
// core_seq_ctrl_if : decoder/bus handshake bundle for the core sequencer
// Rev 1.0
// ==========================================================================
interface core_seq_ctrl_if #(
  parameter int CNT_WIDTH = 32
) ();
  logic [6:0]           opcode;
  logic                 wr_reg;
  logic                 branch_taken;
  logic                 imem_ack;
  logic                 dmem_ack;
  logic                 imem_req;
  logic                 ir_we;
  logic                 dmem_req;
  logic                 dmem_we;
  logic                 rf_we;
  logic                 pc_we;
  logic                 pc_sel;
  logic                 trap;
  logic [2:0]           state;
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    input  opcode, wr_reg, branch_taken, imem_ack, dmem_ack,
    output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap,
           state, instret
  );

  modport slave (
    output opcode, wr_reg, branch_taken, imem_ack, dmem_ack,
    input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap,
           state, instret
  );
endinterface
`default_nettype wire

// File: rtl/core_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// core_seq_ctrl : multi-cycle fetch/decode/exec/mem/wb sequencer with traps
// Rev 1.0
// ==========================================================================
module core_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic            clk,
  input  logic            rst,
  core_seq_ctrl_if.master bus
);
  localparam int c_wait_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_SPARE  = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic [c_wait_w-1:0]  wait_q, wait_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;

  logic is_load, is_store, is_branch, is_jump, is_legal;

  assign is_load   = (bus.opcode == c_op_load);
  assign is_store  = (bus.opcode == c_op_store);
  assign is_branch = (bus.opcode == c_op_branch);
  assign is_jump   = (bus.opcode == c_op_jal) || (bus.opcode == c_op_jalr);
  assign is_legal  = bus.opcode inside {c_op_op, c_op_imm, c_op_load, c_op_store,
                                        c_op_branch, c_op_lui, c_op_auipc,
                                        c_op_jal, c_op_jalr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    instret_d = instret_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        // an ack in the limit cycle still completes the fetch
        if (bus.imem_ack)              state_d = S_DECODE;
        else if (wait_q == c_wait_last) state_d = S_TRAP;
        else                           wait_d  = wait_q + 1'b1;
      end
      S_DECODE: state_d = is_legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dmem_ack)              state_d = S_WB;
        else if (wait_q == c_wait_last) state_d = S_TRAP;
        else                           wait_d  = wait_q + 1'b1;
      end
      S_WB: begin
        state_d   = S_FETCH;
        instret_d = instret_q + 1'b1;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    if (state_d != state_q) wait_d = '0;
  end

  // Outputs decode from the registered state only; acks never reach them.
  always_comb begin
    bus.imem_req = (state_q == S_FETCH);
    bus.ir_we    = (state_q == S_DECODE);
    bus.dmem_req = (state_q == S_MEM);
    bus.dmem_we  = (state_q == S_MEM) && is_store;
    bus.rf_we    = 1'b0;
    bus.pc_we    = 1'b0;
    bus.pc_sel   = 1'b0;
    if (state_q == S_WB) begin
      bus.pc_we  = 1'b1;
      bus.rf_we  = bus.wr_reg && !is_store && !is_branch;
      bus.pc_sel = is_jump || (is_branch && bus.branch_taken);
    end
    bus.trap     = (state_q == S_TRAP);
  end

  assign bus.state   = state_q;
  assign bus.instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_core_seq_ctrl.sv
`default_nettype none
// tb_core_seq_ctrl : instruction plans expand into expected per-cycle traces,
// replayed against the controller, plus literal pins on observed cycles.
module tb_core_seq_ctrl;
  localparam int c_timeout = 16;
  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_seq_ctrl_if #(.CNT_WIDTH(32)) bus ();
  core_seq_ctrl #(.TIMEOUT_CYCLES(c_timeout), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // str bits: {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap}
  typedef struct {
    logic [2:0]  st;
    logic [7:0]  str;
    logic [31:0] cnt;
    logic        iack;
    logic        dack;
    logic [6:0]  op;
    logic        wr;
    logic        bt;
  } rec_t;

  rec_t        exp_q[$];
  logic [2:0]  obs_st[$];
  logic [7:0]  obs_str[$];
  logic [31:0] obs_cnt[$];
  logic [31:0] m_cnt;
  logic [6:0]  m_op;
  logic        m_wr, m_bt;
  bit          noise_en;
  int          checks = 0;
  int          failures = 0;
  logic [6:0]  legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                 7'b1100111};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] act_str();
    return {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
            bus.rf_we, bus.pc_we, bus.pc_sel, bus.trap};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic nz();
    return noise_en && ($urandom_range(0, 4) == 0);
  endfunction

  function automatic void push(input logic [2:0] st, input logic [7:0] str,
                               input logic ia, input logic da);
    rec_t r;
    r.st = st; r.str = str; r.cnt = m_cnt; r.iack = ia; r.dack = da;
    r.op = m_op; r.wr = m_wr; r.bt = m_bt;
    exp_q.push_back(r);
  endfunction

  function automatic void push_trap(input int n);
    for (int i = 0; i < n; i++) push(3'd6, 8'h01, nz(), nz());
  endfunction

  // fd/md: cycle of the req window in which ack arrives, 0 = never
  function automatic bit plan_instr(input logic [6:0] op, input logic wr, input logic bt,
                                    input int fd, input int md);
    int   n;
    logic rf, sel;
    m_op = op; m_wr = wr; m_bt = bt;
    n = (fd == 0) ? c_timeout : fd;
    for (int i = 1; i <= n; i++) push(3'd1, 8'b1000_0000, logic'(i == fd), 1'b0);
    if (fd == 0) return 1'b1;
    push(3'd2, 8'b0100_0000, nz(), nz());
    if (!is_legal(op)) return 1'b1;
    push(3'd3, 8'h00, nz(), nz());
    if (op == c_op_load || op == c_op_store) begin
      n = (md == 0) ? c_timeout : md;
      for (int i = 1; i <= n; i++)
        push(3'd4, {2'b00, 1'b1, logic'(op == c_op_store), 4'b0000}, 1'b0, logic'(i == md));
      if (md == 0) return 1'b1;
    end
    rf  = wr && (op != c_op_store) && (op != c_op_branch);
    sel = (op == c_op_jal) || (op == 7'b1100111) || ((op == c_op_branch) && bt);
    push(3'd5, {4'b0000, rf, 1'b1, sel, 1'b0}, nz(), nz());
    m_cnt = m_cnt + 32'd1;
    return 1'b0;
  endfunction

  task automatic run_n(input int n);
    rec_t r;
    int   k = 0;
    while (exp_q.size() > 0 && k < n) begin
      r = exp_q.pop_front();
      bus.opcode = r.op; bus.wr_reg = r.wr; bus.branch_taken = r.bt;
      bus.imem_ack = r.iack; bus.dmem_ack = r.dack;
      #1;
      obs_st.push_back(bus.state);
      obs_str.push_back(act_str());
      obs_cnt.push_back(bus.instret);
      chk("state", 32'(bus.state), 32'(r.st));
      chk("strobes", 32'(act_str()), 32'(r.str));
      chk("instret", bus.instret, r.cnt);
      k++;
      @(negedge clk);
    end
    exp_q.delete();
  endtask

  task automatic do_reset(input bit seed);
    rst = 1'b1; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_outs", 32'(act_str()), 32'd0);
    @(negedge clk); #1;
    chk("rst_instret", bus.instret, 32'd0);
    @(negedge clk);
    obs_st.delete(); obs_str.delete(); obs_cnt.delete(); exp_q.delete();
    if (seed) begin
      force dut.instret_d = 32'hFFFF_FFFF;
      fork
        begin
          @(posedge clk); #1;
          release dut.instret_d;
        end
      join_none
    end
    rst = 1'b0;
    m_cnt = 32'd0;
    push(3'd0, 8'h00, nz(), nz());
    if (seed) m_cnt = 32'hFFFF_FFFF;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    bus.opcode = 7'd0; bus.wr_reg = 1'b0; bus.branch_taken = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    m_cnt = 32'd0; m_op = 7'd0; m_wr = 1'b0; m_bt = 1'b0; noise_en = 1'b0;
    @(negedge clk);

    // ALU, load, store, branches, jumps, then an illegal opcode
    do_reset(1'b0);
    noise_en = 1'b1;
    void'(plan_instr(c_op_imm,    1'b1, 1'b0, 1, 0));
    void'(plan_instr(c_op_load,   1'b1, 1'b0, 1, 4));
    void'(plan_instr(c_op_store,  1'b1, 1'b0, 1, 1));
    void'(plan_instr(c_op_branch, 1'b1, 1'b1, 1, 0));
    void'(plan_instr(c_op_branch, 1'b1, 1'b0, 1, 0));
    void'(plan_instr(c_op_jal,    1'b1, 1'b0, 1, 0));
    void'(plan_instr(c_op_jal,    1'b0, 1'b0, 1, 0));
    void'(plan_instr(7'b1111111,  1'b1, 1'b0, 1, 0));
    push_trap(20);
    run_n(1000);
    chk("t1_states", 32'({obs_st[0], obs_st[1], obs_st[2], obs_st[3], obs_st[4], obs_st[5]}),
        32'(18'o012351));
    chk("t1_wb", 32'(obs_str[4]), 32'h0C);
    chk("t1_instret", obs_cnt[5], 32'd1);
    c = 0;
    for (int i = 5; i <= 12; i++) c += int'(obs_str[i][5]);
    chk("t2_dreq_cycles", 32'(c), 32'd4);
    chk("t2_load_we", 32'(obs_str[8][4]), 32'd0);
    chk("t2_load_rf", 32'(obs_str[12][3]), 32'd1);
    chk("t2_store_we", 32'(obs_str[16][4]), 32'd1);
    chk("t2_store_rf", 32'(obs_str[17][3]), 32'd0);
    chk("t3_br_taken", 32'(obs_str[21]), 32'h06);
    chk("t3_br_not", 32'(obs_str[25]), 32'h04);
    chk("t3_jal_wr1", 32'(obs_str[29]), 32'h0E);
    chk("t3_jal_wr0", 32'(obs_str[33]), 32'h06);
    c = 0;
    for (int i = 36; i <= 55; i++)
      if (obs_st[i] == 3'd6 && obs_str[i] == 8'h01 && obs_cnt[i] == 32'd7) c++;
    chk("t4_trap_hold", 32'(c), 32'd20);

    // fetch timeout, then ack in the limit cycle
    do_reset(1'b0);
    void'(plan_instr(c_op_imm, 1'b1, 1'b0, 0, 0));
    push_trap(3);
    run_n(1000);
    c = 0;
    foreach (obs_st[i]) if (obs_st[i] == 3'd1) c++;
    chk("t5_fetch_cycles", 32'(c), 32'd16);
    chk("t5_trap_state", 32'(obs_st[17]), 32'd6);
    do_reset(1'b0);
    void'(plan_instr(c_op_op, 1'b1, 1'b0, c_timeout, 0));
    run_n(1000);
    chk("t5_late_ack", 32'({obs_st[16], obs_st[17]}), 32'(6'o12));
    chk("t5_ir_we", 32'(obs_str[17]), 32'h40);

    // counter wrap, then reset in the middle of a data access
    do_reset(1'b1);
    void'(plan_instr(c_op_load, 1'b1, 1'b0, 1, 2));
    void'(plan_instr(c_op_load, 1'b1, 1'b0, 1, 5));
    run_n(11);
    chk("t6_seed", obs_cnt[1], 32'hFFFF_FFFF);
    chk("t6_wrap", obs_cnt[7], 32'd0);
    #1;
    chk("t6_pre_dreq", 32'(bus.dmem_req), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_dreq", 32'(bus.dmem_req), 32'd0);
    chk("t6_async_state", 32'(bus.state), 32'd0);
    @(negedge clk);

    // randomized instruction stream
    do_reset(1'b0);
    for (int k = 0; k < 300; k++) begin
      logic [6:0] op;
      int         fd, md, r;
      bit         tr;
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      else                           op = legal_ops[$urandom_range(0, 8)];
      r  = $urandom_range(0, 39);
      fd = (r == 0) ? 0 : (r < 8) ? $urandom_range(1, c_timeout) : $urandom_range(1, 2);
      r  = $urandom_range(0, 39);
      md = (r == 0) ? 0 : (r < 8) ? $urandom_range(1, c_timeout) : $urandom_range(1, 2);
      tr = plan_instr(op, 1'($urandom), 1'($urandom), fd, md);
      if (tr) push_trap($urandom_range(1, 6));
      run_n(1000);
      if (tr) do_reset(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
